// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control unit for a multicycle RV32I datapath. A Moore FSM steps one state
//   per cycle, driving the datapath muxes and enables. Illegal opcodes or
//   funct fields park the FSM in a sticky HALT state. Completed instructions
//   are counted in a wrapping counter.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   opc/f3/f7   in   instruction fields instr[6:0], [14:12], [31:25]
//   zero/neg    in   ALU result == 0 / ALU result sign bit
//   PCWrite     out  PC load
//   adrSrc      out  memory address select (0 = PC, 1 = Result)
//   memWrite    out  memory write enable
//   IRWrite     out  IR/OldPC load
//   regWrite    out  register file write enable
//   resultSrc   out  0 = ALUOut, 1 = Data, 2 = ALUResult, 3 = ImmExt
//   ALUSrcA     out  0 = PC, 1 = OldPC, 2 = A, 3 = zero
//   ALUSrcB     out  0 = B, 1 = ImmExt, 2 = 4, 3 = zero
//   ALUControl  out  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR
//   immSrc      out  000 I, 001 S, 010 B, 011 J, 100 U
//   instr_done  out  one-cycle pulse in the last state of an instruction
//   halted      out  sticky illegal-instruction flag
//   retired     out  count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opc,
   input  logic [2:0]       f3,
   input  logic [6:0]       f7,
   input  logic             zero,
   input  logic             neg,
   output logic             PCWrite,
   output logic             adrSrc,
   output logic             memWrite,
   output logic             IRWrite,
   output logic             regWrite,
   output logic [1:0]       resultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUControl,
   output logic [2:0]       immSrc,
   output logic             instr_done,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam logic [6:0] OpR    = 7'b0110011;
   localparam logic [6:0] OpI    = 7'b0010011;
   localparam logic [6:0] OpLw   = 7'b0000011;
   localparam logic [6:0] OpSw   = 7'b0100011;
   localparam logic [6:0] OpBr   = 7'b1100011;
   localparam logic [6:0] OpJal  = 7'b1101111;
   localparam logic [6:0] OpJalr = 7'b1100111;
   localparam logic [6:0] OpLui  = 7'b0110111;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b100;
   localparam logic [2:0] AluXor = 3'b101;

   localparam logic [1:0] SrcAPc    = 2'd0;
   localparam logic [1:0] SrcAOldPc = 2'd1;
   localparam logic [1:0] SrcAReg   = 2'd2;
   localparam logic [1:0] SrcBReg   = 2'd0;
   localparam logic [1:0] SrcBImm   = 2'd1;
   localparam logic [1:0] SrcBFour  = 2'd2;

   localparam logic [1:0] ResAluOut = 2'd0;
   localparam logic [1:0] ResData   = 2'd1;
   localparam logic [1:0] ResAluRes = 2'd2;
   localparam logic [1:0] ResImm    = 2'd3;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StJal,
      StJalr,
      StLink,
      StLui,
      StHalt
   } state_e;

   state_e           r_state_q;
   state_e           r_state_d;
   logic [CNT_W-1:0] r_retired;

   logic       w_pc_write;
   logic       w_adr_src;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic [1:0] w_result_src;
   logic [1:0] w_src_a;
   logic [1:0] w_src_b;
   logic [2:0] w_alu_ctrl;
   logic       w_done;
   logic       w_alu_f3_legal;
   logic       w_r_legal;
   logic       w_br_legal;
   logic       w_br_taken;
   logic [2:0] w_alu_op;

   // Shared ALU-op decode for R and I forms; SUB only when the R-type f7 says so.
   always_comb begin
      w_alu_f3_legal = 1'b1;
      w_alu_op       = AluAdd;
      unique case (f3)
         3'b000: w_alu_op = (opc == OpR && f7 == 7'b0100000) ? AluSub : AluAdd;
         3'b111: w_alu_op = AluAnd;
         3'b110: w_alu_op = AluOr;
         3'b100: w_alu_op = AluXor;
         3'b010: w_alu_op = AluSlt;
         default: begin
            w_alu_op       = AluAdd;
            w_alu_f3_legal = 1'b0;
         end
      endcase
   end

   // R-type: f7 must be zero, except SUB which needs 0100000 with f3=000.
   assign w_r_legal = w_alu_f3_legal &&
                      ((f7 == 7'b0000000) || (f7 == 7'b0100000 && f3 == 3'b000));

   assign w_br_legal = (f3 == 3'b000) || (f3 == 3'b001) ||
                       (f3 == 3'b100) || (f3 == 3'b101);

   always_comb begin
      w_br_taken = 1'b0;
      case (f3)
         3'b000:  w_br_taken = zero;
         3'b001:  w_br_taken = ~zero;
         3'b100:  w_br_taken = neg;
         3'b101:  w_br_taken = ~neg;
         default: w_br_taken = 1'b0;
      endcase
   end

   // Immediate format follows the opcode in every state.
   always_comb begin
      immSrc = 3'b000;
      case (opc)
         OpSw:    immSrc = 3'b001;
         OpBr:    immSrc = 3'b010;
         OpJal:   immSrc = 3'b011;
         OpLui:   immSrc = 3'b100;
         default: immSrc = 3'b000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state_q <= StFetch;
      end else begin
         r_state_q <= r_state_d;
      end
   end

   always_comb begin
      r_state_d    = r_state_q;
      w_pc_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_result_src = ResAluOut;
      w_src_a      = SrcAPc;
      w_src_b      = SrcBReg;
      w_alu_ctrl   = AluAdd;
      w_done       = 1'b0;

      unique case (r_state_q)
         StFetch: begin
            w_ir_write   = 1'b1;
            w_pc_write   = 1'b1;
            w_src_a      = SrcAPc;
            w_src_b      = SrcBFour;
            w_result_src = ResAluRes;
            r_state_d    = StDecode;
         end
         StDecode: begin
            // ALUOut captures OldPC + imm: the branch/jal target.
            w_src_a = SrcAOldPc;
            w_src_b = SrcBImm;
            case (opc)
               OpLw, OpSw: r_state_d = StMemAdr;
               OpR:        r_state_d = w_r_legal ? StExecR : StHalt;
               OpI:        r_state_d = w_alu_f3_legal ? StExecI : StHalt;
               OpBr:       r_state_d = w_br_legal ? StBranch : StHalt;
               OpJal:      r_state_d = StJal;
               OpJalr:     r_state_d = StJalr;
               OpLui:      r_state_d = StLui;
               default:    r_state_d = StHalt;
            endcase
         end
         StMemAdr: begin
            w_src_a   = SrcAReg;
            w_src_b   = SrcBImm;
            r_state_d = (opc == OpSw) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            w_adr_src    = 1'b1;
            w_result_src = ResAluOut;
            r_state_d    = StMemWb;
         end
         StMemWb: begin
            w_result_src = ResData;
            w_reg_write  = 1'b1;
            w_done       = 1'b1;
            r_state_d    = StFetch;
         end
         StMemWrite: begin
            w_adr_src    = 1'b1;
            w_result_src = ResAluOut;
            w_mem_write  = 1'b1;
            w_done       = 1'b1;
            r_state_d    = StFetch;
         end
         StExecR: begin
            w_src_a    = SrcAReg;
            w_src_b    = SrcBReg;
            w_alu_ctrl = w_alu_op;
            r_state_d  = StAluWb;
         end
         StExecI: begin
            w_src_a    = SrcAReg;
            w_src_b    = SrcBImm;
            w_alu_ctrl = w_alu_op;
            r_state_d  = StAluWb;
         end
         StAluWb: begin
            w_result_src = ResAluOut;
            w_reg_write  = 1'b1;
            w_done       = 1'b1;
            r_state_d    = StFetch;
         end
         StBranch: begin
            w_src_a      = SrcAReg;
            w_src_b      = SrcBReg;
            w_alu_ctrl   = AluSub;
            w_result_src = ResAluOut;
            w_pc_write   = w_br_taken;
            w_done       = 1'b1;
            r_state_d    = StFetch;
         end
         StJal: begin
            w_result_src = ResAluOut;
            w_pc_write   = 1'b1;
            r_state_d    = StLink;
         end
         StJalr: begin
            w_src_a      = SrcAReg;
            w_src_b      = SrcBImm;
            w_result_src = ResAluRes;
            w_pc_write   = 1'b1;
            r_state_d    = StLink;
         end
         StLink: begin
            // rd <= OldPC + 4
            w_src_a      = SrcAOldPc;
            w_src_b      = SrcBFour;
            w_result_src = ResAluRes;
            w_reg_write  = 1'b1;
            w_done       = 1'b1;
            r_state_d    = StFetch;
         end
         StLui: begin
            w_result_src = ResImm;
            w_reg_write  = 1'b1;
            w_done       = 1'b1;
            r_state_d    = StFetch;
         end
         StHalt: begin
            r_state_d = StHalt;
         end
         default: begin
            r_state_d = StHalt;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_retired <= '0;
      end else if (w_done) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Enables are gated by rst so nothing writes while reset is held, even
   // though the reset state (FETCH) would otherwise request PC/IR loads.
   assign PCWrite    = w_pc_write  & rst;
   assign IRWrite    = w_ir_write  & rst;
   assign memWrite   = w_mem_write & rst;
   assign regWrite   = w_reg_write & rst;
   assign instr_done = w_done      & rst;
   assign adrSrc     = w_adr_src;
   assign resultSrc  = w_result_src;
   assign ALUSrcA    = w_src_a;
   assign ALUSrcB    = w_src_b;
   assign ALUControl = w_alu_ctrl;
   assign halted     = (r_state_q == StHalt);
   assign retired    = r_retired;

endmodule
